uart_cfg: RTL

Parametrised full-duplex UART that generalises the fixed 115 200 Bd / 8N1 UART. Clock rate, baud rate, data width, parity mode and stop-bit count are compile-time parameters. It adds a valid/ready transmit handshake, mid-bit receive sampling with false-start rejection, and per-frame parity and framing error flags. It sits between the board serial pins and the packet/register logic and drops in where the fixed UART is used today.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_cfg.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, state encodings and helper functions for the configurable UART.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_t;

    localparam int MAX_DATA_BITS = 9;

    // State encodings are plain constants so older blocks can compare against them directly
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE   = 3'd0;
    localparam tx_state_t TX_START  = 3'd1;
    localparam tx_state_t TX_DATA   = 3'd2;
    localparam tx_state_t TX_PARITY = 3'd3;
    localparam tx_state_t TX_STOP   = 3'd4;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE   = 3'd0;
    localparam rx_state_t RX_START  = 3'd1;
    localparam rx_state_t RX_DATA   = 3'd2;
    localparam rx_state_t RX_PARITY = 3'd3;
    localparam rx_state_t RX_STOP   = 3'd4;
    localparam rx_state_t RX_BREAK  = 3'd5;

    // Clocks per bit, rounded to the nearest integer
    function automatic int unsigned cpb(input int unsigned clkHz, input int unsigned baud);
        return (clkHz + baud / 2) / baud;
    endfunction

    // Parity bit for a payload; unused upper bits must be zero so they do not disturb the XOR
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input parity_t mode);
        case (mode)
            PARITY_EVEN: return ^data;
            PARITY_ODD:  return ~(^data);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: loading a period of N gives a terminal-count pulse N cycles later.
module uart_bit_timer #(
    parameter int WIDTH = 9
) (
    input  logic           ipClk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [WIDTH:0] period_i,
    output logic           tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load stores N-1 so that the zero state is the Nth cycle; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = WIDTH'(period_i - (WIDTH+1)'(1));
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge ipClk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART with valid/ready transmit and mid-bit sampling receive.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter parity_t     PARITY    = PARITY_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 ipClk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] ipTxData,
    input  logic                 ipTxValid,
    output logic                 opTxReady,
    output logic                 opTx,
    input  logic                 ipRx,
    output logic [DATA_BITS-1:0] opRxData,
    output logic                 opRxValid,
    output logic                 opRxParityErr,
    output logic                 opRxFrameErr
);

    localparam int unsigned CPB = cpb(CLK_HZ, BAUD);
    localparam int          W   = $clog2(CPB);
    localparam int          WP1 = W + 1;
    localparam logic [W:0]  FULL_PERIOD = WP1'(CPB);
    localparam logic [W:0]  HALF_PERIOD = WP1'(CPB / 2);
    localparam logic [3:0]  LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);
    localparam bit          HAS_PARITY  = (PARITY != PARITY_NONE);

    if (CPB < 4) begin : gBadCpb
        $error("uart_cfg: clocks per bit must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadData
        $error("uart_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
        $error("uart_cfg: STOP_BITS must be 1 or 2");
    end

    // ---------------- transmitter ----------------
    tx_state_t            txState_q, txState_d;
    logic [DATA_BITS-1:0] txShift_q, txShift_d;
    logic                 txPar_q, txPar_d;
    logic [3:0]           txBitCnt_q, txBitCnt_d;
    logic                 txLoad;
    logic                 txTc;

    uart_bit_timer #(.WIDTH(W)) txTimer (
        .ipClk    (ipClk),
        .rst      (rst),
        .load_i   (txLoad),
        .period_i (FULL_PERIOD),
        .tc_o     (txTc)
    );

    // Transmit sequencing: every state transition reloads a full bit period except the return to idle
    always_comb begin
        txState_d  = txState_q;
        txShift_d  = txShift_q;
        txPar_d    = txPar_q;
        txBitCnt_d = txBitCnt_q;
        txLoad     = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                if (ipTxValid) begin
                    txShift_d = ipTxData;
                    txPar_d   = parity_bit(MAX_DATA_BITS'(ipTxData), PARITY);
                    txState_d = TX_START;
                    txLoad    = 1'b1;
                end
            end
            TX_START: begin
                if (txTc) begin
                    txState_d  = TX_DATA;
                    txBitCnt_d = 4'd0;
                    txLoad     = 1'b1;
                end
            end
            TX_DATA: begin
                if (txTc) begin
                    txShift_d = txShift_q >> 1;
                    txLoad    = 1'b1;
                    if (txBitCnt_q == LAST_DATA) begin
                        txBitCnt_d = 4'd0;
                        txState_d  = HAS_PARITY ? TX_PARITY : TX_STOP;
                    end else begin
                        txBitCnt_d = txBitCnt_q + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (txTc) begin
                    txState_d  = TX_STOP;
                    txBitCnt_d = 4'd0;
                    txLoad     = 1'b1;
                end
            end
            TX_STOP: begin
                if (txTc) begin
                    if (txBitCnt_q == LAST_STOP) begin
                        txState_d = TX_IDLE;
                    end else begin
                        txBitCnt_d = txBitCnt_q + 4'd1;
                        txLoad     = 1'b1;
                    end
                end
            end
            default: txState_d = TX_IDLE;
        endcase
    end

    // Transmit registers
    always_ff @(posedge ipClk) begin
        if (rst) begin
            txState_q  <= TX_IDLE;
            txShift_q  <= '0;
            txPar_q    <= 1'b0;
            txBitCnt_q <= 4'd0;
        end else begin
            txState_q  <= txState_d;
            txShift_q  <= txShift_d;
            txPar_q    <= txPar_d;
            txBitCnt_q <= txBitCnt_d;
        end
    end

    // Line level follows the registered state, so it changes in the cycle after each transition
    always_comb begin
        case (txState_q)
            TX_START:  opTx = 1'b0;
            TX_DATA:   opTx = txShift_q[0];
            TX_PARITY: opTx = txPar_q;
            default:   opTx = 1'b1;
        endcase
    end

    assign opTxReady = (txState_q == TX_IDLE);

    // ---------------- receiver ----------------
    logic                 rxMeta_q, rxs_q;
    rx_state_t            rxState_q, rxState_d;
    logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
    logic [3:0]           rxBitCnt_q, rxBitCnt_d;
    logic                 rxParBad_q, rxParBad_d;
    logic [DATA_BITS-1:0] rxData_q, rxData_d;
    logic                 rxValid_q, rxValid_d;
    logic                 rxParErr_q, rxParErr_d;
    logic                 rxFrameErr_q, rxFrameErr_d;
    logic                 rxLoad;
    logic [W:0]           rxPeriod;
    logic                 rxTc;

    uart_bit_timer #(.WIDTH(W)) rxTimer (
        .ipClk    (ipClk),
        .rst      (rst),
        .load_i   (rxLoad),
        .period_i (rxPeriod),
        .tc_o     (rxTc)
    );

    // Receive sequencing: half a bit to the start centre, then whole bits; flags exist only with the valid pulse
    always_comb begin
        rxState_d    = rxState_q;
        rxShift_d    = rxShift_q;
        rxBitCnt_d   = rxBitCnt_q;
        rxParBad_d   = rxParBad_q;
        rxData_d     = rxData_q;
        rxValid_d    = 1'b0;
        rxParErr_d   = 1'b0;
        rxFrameErr_d = 1'b0;
        rxLoad       = 1'b0;
        rxPeriod     = FULL_PERIOD;
        case (rxState_q)
            RX_IDLE: begin
                // rxs is high and about to take the low value already in the first flop
                if (rxs_q && !rxMeta_q) begin
                    rxState_d  = RX_START;
                    rxParBad_d = 1'b0;
                    rxLoad     = 1'b1;
                    rxPeriod   = HALF_PERIOD;
                end
            end
            RX_START: begin
                if (rxTc) begin
                    if (rxs_q) begin
                        rxState_d = RX_IDLE;
                    end else begin
                        rxState_d  = RX_DATA;
                        rxBitCnt_d = 4'd0;
                        rxLoad     = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rxTc) begin
                    rxShift_d = {rxs_q, rxShift_q[DATA_BITS-1:1]};
                    rxLoad    = 1'b1;
                    if (rxBitCnt_q == LAST_DATA) begin
                        rxBitCnt_d = 4'd0;
                        rxState_d  = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        rxBitCnt_d = rxBitCnt_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rxTc) begin
                    rxParBad_d = rxs_q ^ parity_bit(MAX_DATA_BITS'(rxShift_q), PARITY);
                    rxState_d  = RX_STOP;
                    rxLoad     = 1'b1;
                end
            end
            RX_STOP: begin
                if (rxTc) begin
                    rxValid_d    = 1'b1;
                    rxData_d     = rxShift_q;
                    rxParErr_d   = rxParBad_q;
                    rxFrameErr_d = ~rxs_q;
                    rxState_d    = rxs_q ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rxs_q) begin
                    rxState_d = RX_IDLE;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Synchroniser and receive registers; the synchroniser resets to the idle line level
    always_ff @(posedge ipClk) begin
        if (rst) begin
            rxMeta_q     <= 1'b1;
            rxs_q        <= 1'b1;
            rxState_q    <= RX_IDLE;
            rxShift_q    <= '0;
            rxBitCnt_q   <= 4'd0;
            rxParBad_q   <= 1'b0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            rxParErr_q   <= 1'b0;
            rxFrameErr_q <= 1'b0;
        end else begin
            rxMeta_q     <= ipRx;
            rxs_q        <= rxMeta_q;
            rxState_q    <= rxState_d;
            rxShift_q    <= rxShift_d;
            rxBitCnt_q   <= rxBitCnt_d;
            rxParBad_q   <= rxParBad_d;
            rxData_q     <= rxData_d;
            rxValid_q    <= rxValid_d;
            rxParErr_q   <= rxParErr_d;
            rxFrameErr_q <= rxFrameErr_d;
        end
    end

    assign opRxData      = rxData_q;
    assign opRxValid     = rxValid_q;
    assign opRxParityErr = rxParErr_q;
    assign opRxFrameErr  = rxFrameErr_q;

endmodule
